// File: rtl/hfifo_pkg.sv
// Shared definitions for the hfifo block family: FSM encodings, widths and
// a constant-evaluable clog2.
package hfifo_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W = 16;

  // Returns at least 0; clog2(1) == 0, so index widths need N >= 2.
  function automatic int clog2(input int n);
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) >= n) return r;
    end
    return 31;
  endfunction

endpackage

// File: rtl/hfifo_rr_pick.sv
// Round-robin pick: first asserted request after rr_ptr, wrapping modulo N_REQ.
// A double-width rotate puts the search start at bit 0 so a plain priority encode works.
module hfifo_rr_pick
  import hfifo_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [IW-1:0]    winner,
  output logic             any_req
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  int                 start;

  always_comb begin
    start   = (int'(rr_ptr) + 1) % N_REQ;
    dbl     = {req, req} >> start;
    rot     = dbl[N_REQ-1:0];
    any_req = |req;
    winner  = '0;
    // Descending scan so the lowest rotated position wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) winner = IW'((start + i) % N_REQ);
    end
  end

endmodule

// File: rtl/hfifo_wr_arb.sv
// Round-robin arbiter sharing one hfifo write port among N_REQ valid/ready producers,
// granting bursts of up to BURST words with a one-cycle arbitration bubble.
module hfifo_wr_arb
  import hfifo_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int BURST  = 8
) (
  input  logic                    SYSTEM_CLOCK,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_din,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  localparam int IW = clog2(N_REQ);
  localparam int CW = clog2(BURST) + 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] winner;
  logic          any_req;
  logic          active;
  logic          owner_valid;
  logic          xfer;

  hfifo_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req     (req_valid),
    .rr_ptr  (rr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Reset masks the outputs in the same cycle so an aborted burst never issues a partial write.
  assign active      = (state_q == ST_BUSY) && !reset;
  assign owner_valid = req_valid[owner_q];
  assign xfer        = active && owner_valid && !fifo_full;

  always_ff @(posedge SYSTEM_CLOCK) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= LAST_IDX;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    count_d    = count_q;
    req_ready  = '0;
    grant      = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    busy       = 1'b0;

    if (active) begin
      busy               = 1'b1;
      grant[owner_q]     = 1'b1;
      req_ready[owner_q] = !fifo_full;
      fifo_wr_en         = xfer;
      fifo_din           = req_data[int'(owner_q)*DATA_W +: DATA_W];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_BUSY;
          owner_d = winner;
          rr_d    = winner;
          count_d = '0;
        end
      end
      ST_BUSY: begin
        // Release on a dropped valid takes priority over a simultaneous full.
        if (!owner_valid) begin
          state_d = ST_IDLE;
        end else if (xfer && count_q == LAST_BEAT) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hfifo_wr_arb.sv
// Self-checking bench for hfifo_wr_arb: directed scenarios with table/arithmetic
// expectations, then a randomized run against a round-robin scoreboard.
module tb_hfifo_wr_arb;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int BURST = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic [N-1:0]    grant;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  int sent[N];

  always #5 clk = ~clk;

  hfifo_wr_arb #(.N_REQ(N), .DATA_W(DW), .BURST(BURST)) dut (
    .SYSTEM_CLOCK (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_din     (fifo_din),
    .grant        (grant),
    .busy         (busy)
  );

  // Producer i sends tagged words: index in the top 2 bits, sequence number below.
  function automatic logic [DW-1:0] word_of(int i, int seq);
    return {2'(i), 14'(seq)};
  endfunction

  task automatic set_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = word_of(i, sent[i]);
  endtask

  // Producers advance on valid&ready seen just before the edge; inputs change 1ns after it.
  task automatic next_cycle();
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) sent[i]++;
    @(posedge clk);
    #1;
    set_data();
  endtask

  task automatic do_reset(int n);
    reset     = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    for (int k = 0; k < n; k++) next_cycle();
    reset = 1'b0;
    for (int i = 0; i < N; i++) sent[i] = 0;
    set_data();
  endtask

  function automatic int rr_ref(int last, logic [N-1:0] v);
    for (int d = 1; d <= N; d++) if (v[(last + d) % N]) return (last + d) % N;
    return -1;
  endfunction

  task automatic test_reset();
    for (int k = 0; k < 15; k++) begin
      #1;
      n_checks++;
      if (grant !== '0 || busy !== 1'b0 || fifo_wr_en !== 1'b0 || fifo_din !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: grant=%b busy=%b wr_en=%b din=%h, want 0", k, grant, busy, fifo_wr_en, fifo_din);
      end
      next_cycle();
    end
    reset     = 1'b0;
    req_valid = 4'b0100;
    #1;
    n_checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: grant=%b busy=%b, want 0 0", grant, busy);
    end
    next_cycle();
    #1;
    n_checks++;
    if (grant !== 4'b0100 || fifo_wr_en !== 1'b1 || fifo_din !== word_of(2, 0) || req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_first_grant: grant=%b wr_en=%b din=%h ready=%b, want 0100 1 %h 0100",
               grant, fifo_wr_en, fifo_din, req_ready, word_of(2, 0));
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    int b, ph, src;
    logic [N-1:0] exp_g;
    logic exp_we;
    do_reset(2);
    req_valid = 4'hF;
    for (int k = 0; k < 5 * (BURST + 1); k++) begin
      #1;
      b      = k / (BURST + 1);
      ph     = k % (BURST + 1);
      src    = b % N;
      exp_g  = (ph == 0) ? '0 : N'(1 << src);
      exp_we = (ph != 0);
      n_checks++;
      if (grant !== exp_g || fifo_wr_en !== exp_we) begin
        n_fail++;
        $display("FAIL rr_sched cyc%0d: grant=%b wr_en=%b, want %b %b", k, grant, fifo_wr_en, exp_g, exp_we);
      end
      if (exp_we) begin
        n_checks++;
        if (fifo_din !== word_of(src, sent[src])) begin
          n_fail++;
          $display("FAIL rr_data cyc%0d: din=%h want %h", k, fifo_din, word_of(src, sent[src]));
        end
      end
      next_cycle();
    end
    req_valid = '0;
    next_cycle();
  endtask

  task automatic test_early_release();
    logic [N-1:0] exp_g[7]  = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000};
    logic         exp_we[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int           exp_s[7]  = '{0, 1, 1, 1, 0, 0, 3};
    do_reset(2);
    for (int k = 0; k < 7; k++) begin
      req_valid = {1'b1, 1'b0, (sent[1] < 3), 1'b0};
      #1;
      n_checks++;
      if (grant !== exp_g[k] || fifo_wr_en !== exp_we[k]) begin
        n_fail++;
        $display("FAIL early_release cyc%0d: grant=%b wr_en=%b, want %b %b", k, grant, fifo_wr_en, exp_g[k], exp_we[k]);
      end
      if (exp_we[k]) begin
        n_checks++;
        if (fifo_din !== word_of(exp_s[k], sent[exp_s[k]])) begin
          n_fail++;
          $display("FAIL early_release_data cyc%0d: din=%h want %h", k, fifo_din, word_of(exp_s[k], sent[exp_s[k]]));
        end
      end
      next_cycle();
    end
    req_valid = '0;
    next_cycle();
  endtask

  task automatic test_backpressure();
    int writes = 0;
    logic exp_we, full;
    logic [N-1:0] exp_g, exp_r;
    do_reset(2);
    req_valid = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      full      = (k >= 5 && k < 10);
      fifo_full = full;
      exp_we    = (k >= 1 && k <= 4) || (k >= 10 && k <= 13) || k == 15;
      exp_g     = (k == 0 || k == 14) ? 4'b0000 : 4'b0001;
      exp_r     = full ? 4'b0000 : exp_g;
      #1;
      n_checks++;
      if (grant !== exp_g || fifo_wr_en !== exp_we || req_ready !== exp_r) begin
        n_fail++;
        $display("FAIL backpressure cyc%0d: grant=%b wr_en=%b ready=%b, want %b %b %b",
                 k, grant, fifo_wr_en, req_ready, exp_g, exp_we, exp_r);
      end
      if (fifo_wr_en && k <= 13) writes++;
      next_cycle();
    end
    n_checks++;
    if (writes !== BURST) begin
      n_fail++;
      $display("FAIL backpressure_burst_len: got %0d writes, want %0d", writes, BURST);
    end
    req_valid = '0;
    fifo_full = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    do_reset(2);
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k > 0) begin
        n_checks++;
        if (grant !== 4'b0001 || fifo_din !== word_of(0, k - 1)) begin
          n_fail++;
          $display("FAIL midrst_pre cyc%0d: grant=%b din=%h, want 0001 %h", k, grant, fifo_din, word_of(0, k - 1));
        end
      end
      next_cycle();
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (grant !== '0 || fifo_wr_en !== 1'b0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL midrst_abort: grant=%b wr_en=%b ready=%b, want 0 0 0", grant, fifo_wr_en, req_ready);
    end
    next_cycle();
    reset = 1'b0;
    #1;
    n_checks++;
    if (grant !== '0 || busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_after: grant=%b busy=%b wr_en=%b, want 0 0 0", grant, busy, fifo_wr_en);
    end
    next_cycle();
    #1;
    n_checks++;
    if (grant !== 4'b0001 || fifo_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_regrant: grant=%b wr_en=%b, want 0001 1", grant, fifo_wr_en);
    end
    req_valid = '0;
    next_cycle();
  endtask

  task automatic test_data_integrity();
    int           got[N];
    int           last = N - 1;
    int           beats = 0;
    int           total = 0;
    int           cyc = 0;
    int           exp_i, own;
    logic [N-1:0] prev_valid = '0;
    logic [N-1:0] prev_grant = '0;
    do_reset(2);
    for (int i = 0; i < N; i++) got[i] = 0;
    while (total < 100 * N && cyc < 6000) begin
      for (int i = 0; i < N; i++) req_valid[i] = (sent[i] < 100) && ($urandom_range(0, 3) != 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      #1;
      if (grant != '0 && prev_grant == '0) begin
        exp_i = rr_ref(last, prev_valid);
        n_checks++;
        if (exp_i < 0 || grant !== N'(1 << exp_i)) begin
          n_fail++;
          $display("FAIL rand_fairness cyc%0d: grant=%b, want index %0d (last=%0d valid=%b)", cyc, grant, exp_i, last, prev_valid);
        end
        if (exp_i >= 0) last = exp_i;
        beats = 0;
      end
      if (grant != '0 && prev_grant != '0) begin
        n_checks++;
        if (grant !== prev_grant) begin
          n_fail++;
          $display("FAIL rand_grant_switch cyc%0d: grant=%b after %b without idle", cyc, grant, prev_grant);
        end
      end
      if (fifo_wr_en) begin
        own = -1;
        for (int i = 0; i < N; i++) if (grant == N'(1 << i)) own = i;
        n_checks++;
        if (own < 0 || fifo_full || (req_valid & req_ready) !== grant) begin
          n_fail++;
          $display("FAIL rand_write_ctl cyc%0d: grant=%b full=%b vr=%b", cyc, grant, fifo_full, req_valid & req_ready);
        end else begin
          n_checks++;
          if (fifo_din !== word_of(own, got[own])) begin
            n_fail++;
            $display("FAIL rand_data cyc%0d: din=%h want %h", cyc, fifo_din, word_of(own, got[own]));
          end
          got[own]++;
          total++;
          beats++;
          n_checks++;
          if (beats > BURST) begin
            n_fail++;
            $display("FAIL rand_burst_len cyc%0d: %0d beats, max %0d", cyc, beats, BURST);
          end
        end
      end
      prev_valid = req_valid;
      prev_grant = grant;
      next_cycle();
      cyc++;
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (got[i] != 100) begin
        n_fail++;
        $display("FAIL rand_count req%0d: got %0d words, want 100 (cycles %0d)", i, got[i], cyc);
      end
    end
    req_valid = '0;
    fifo_full = 1'b0;
    next_cycle();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) sent[i] = 0;
    set_data();
    test_reset();
    test_round_robin();
    test_early_release();
    test_backpressure();
    test_reset_mid_burst();
    test_data_integrity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
